// File: rtl/alarm_bank.sv
// -----------------------------------------------------------------------------
// alarm_bank
//
// Holds NUM_ALARMS independent HH:MM alarm slots (BCD) with per-slot enables.
// Loads are validated for BCD digit range and slot index. Enabled slots are
// compared against the running time on each time_tick. A ring/snooze state
// machine drives alarm_ring.
//
// Optional build macro: RING_TIMEOUT_EN
//   When defined, an unattended ring stops by itself after RING_TICKS ticks.
//   When undefined, RING_TICKS is unused and no ring counter is built.
//
// Ports:
//   clock, reset           system clock, asynchronous active-high reset
//   load_new_alarm         write new_alarm_* into slot load_slot (if valid)
//   load_slot [SW]         target slot for load / clear
//   new_alarm_*  [4]       BCD alarm time to load
//   clear_slot_en          disable slot load_slot (a same-cycle load wins)
//   time_tick              one-cycle pulse when the current time changes
//   cur_*        [4]       current BCD time, valid when time_tick=1
//   stop_alarm, snooze     user pulses
//   rd_slot [SW]           read-back slot select
//   alarm_time_* [4]       stored time of rd_slot (combinational)
//   rd_slot_en             enable flag of rd_slot
//   alarm_ring             high while RINGING (registered)
//   alarm_hit_slot [SW]    slot that caused the current ring
//   load_err               one-cycle pulse after a rejected load
// -----------------------------------------------------------------------------
module alarm_bank #(
    parameter int NUM_ALARMS = 4,
    parameter int SNOOZE_MIN = 5,
    parameter int RING_TICKS = 10,
    localparam int SW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load_new_alarm,
    input  logic [SW-1:0] load_slot,
    input  logic [3:0]    new_alarm_ms_hr,
    input  logic [3:0]    new_alarm_ls_hr,
    input  logic [3:0]    new_alarm_ms_min,
    input  logic [3:0]    new_alarm_ls_min,
    input  logic          clear_slot_en,
    input  logic          time_tick,
    input  logic [3:0]    cur_ms_hr,
    input  logic [3:0]    cur_ls_hr,
    input  logic [3:0]    cur_ms_min,
    input  logic [3:0]    cur_ls_min,
    input  logic          stop_alarm,
    input  logic          snooze,
    input  logic [SW-1:0] rd_slot,
    output logic [3:0]    alarm_time_ms_hr,
    output logic [3:0]    alarm_time_ls_hr,
    output logic [3:0]    alarm_time_ms_min,
    output logic [3:0]    alarm_time_ls_min,
    output logic          rd_slot_en,
    output logic          alarm_ring,
    output logic [SW-1:0] alarm_hit_slot,
    output logic          load_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZED = 2'd2
    } state_t;

    // Slot storage: one packed HHMM word per slot.
    logic [15:0]           slot_time_reg [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] slot_en_reg;

    logic [15:0] new_time;
    logic [15:0] cur_time;
    logic        time_ok;
    logic        slot_ok;
    logic        load_ok;

    logic [NUM_ALARMS-1:0] load_hit;
    logic [NUM_ALARMS-1:0] clear_hit;
    logic [NUM_ALARMS-1:0] match;
    logic                  any_match;
    logic [SW-1:0]         win_slot;

    logic [15:0] rd_time;
    logic        rd_en;

    state_t        state_reg;
    logic [3:0]    snooze_cnt_reg;
    logic [SW-1:0] hit_slot_reg;
    logic          ring_reg;
    logic          load_err_reg;

    assign new_time = {new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min};
    assign cur_time = {cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min};

    // Hours 00..23, minutes 00..59, every digit plain BCD.
    assign time_ok = (new_alarm_ms_hr <= 4'd2) &&
                     ((new_alarm_ms_hr == 4'd2) ? (new_alarm_ls_hr <= 4'd3)
                                                : (new_alarm_ls_hr <= 4'd9)) &&
                     (new_alarm_ms_min <= 4'd5) &&
                     (new_alarm_ls_min <= 4'd9);
    assign slot_ok = (int'(load_slot) < NUM_ALARMS);
    assign load_ok = load_new_alarm && slot_ok && time_ok;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ALARMS; gi++) begin : g_slot
            assign load_hit[gi]  = load_ok && (load_slot == SW'(gi));
            assign clear_hit[gi] = clear_slot_en && (load_slot == SW'(gi));
            assign match[gi]     = slot_en_reg[gi] && (slot_time_reg[gi] == cur_time);
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                slot_time_reg[i] <= '0;
            end
            slot_en_reg <= '0;
        end else begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (load_hit[i]) begin
                    slot_time_reg[i] <= new_time;
                    slot_en_reg[i]   <= 1'b1;
                end else if (clear_hit[i]) begin
                    slot_en_reg[i]   <= 1'b0;
                end
            end
        end
    end

    // Lowest matching index wins: scan downward so the last hit is the lowest.
    always_comb begin
        any_match = 1'b0;
        win_slot  = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (match[i]) begin
                any_match = 1'b1;
                win_slot  = SW'(i);
            end
        end
    end

    // Read-back mux; a select beyond the last slot reads as zero.
    always_comb begin
        rd_time = '0;
        rd_en   = 1'b0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (rd_slot == SW'(i)) begin
                rd_time = slot_time_reg[i];
                rd_en   = slot_en_reg[i];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            load_err_reg <= 1'b0;
        end else begin
            load_err_reg <= load_new_alarm && !(slot_ok && time_ok);
        end
    end

`ifdef RING_TIMEOUT_EN
    localparam int RW = $clog2(RING_TICKS + 1);
    logic [RW-1:0] ring_cnt_reg;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            snooze_cnt_reg <= '0;
            hit_slot_reg   <= '0;
            ring_reg       <= 1'b0;
`ifdef RING_TIMEOUT_EN
            ring_cnt_reg   <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (time_tick && any_match) begin
                        state_reg    <= RINGING;
                        hit_slot_reg <= win_slot;
                        ring_reg     <= 1'b1;
`ifdef RING_TIMEOUT_EN
                        ring_cnt_reg <= '0;
`endif
                    end
                end
                RINGING: begin
                    // New matches are ignored here; hit slot is held.
                    if (stop_alarm) begin
                        state_reg <= IDLE;
                        ring_reg  <= 1'b0;
                    end else if (snooze) begin
                        state_reg      <= SNOOZED;
                        snooze_cnt_reg <= 4'(SNOOZE_MIN);
                        ring_reg       <= 1'b0;
                    end
`ifdef RING_TIMEOUT_EN
                    else if (time_tick) begin
                        // The tick that would bring the count to RING_TICKS ends the ring.
                        if (ring_cnt_reg == RW'(RING_TICKS - 1)) begin
                            state_reg    <= IDLE;
                            ring_reg     <= 1'b0;
                            ring_cnt_reg <= '0;
                        end else begin
                            ring_cnt_reg <= ring_cnt_reg + 1'b1;
                        end
                    end
`endif
                end
                SNOOZED: begin
                    if (stop_alarm) begin
                        state_reg      <= IDLE;
                        snooze_cnt_reg <= '0;
                    end else if (time_tick) begin
                        if (any_match) begin
                            state_reg      <= RINGING;
                            hit_slot_reg   <= win_slot;
                            snooze_cnt_reg <= '0;
                            ring_reg       <= 1'b1;
`ifdef RING_TIMEOUT_EN
                            ring_cnt_reg   <= '0;
`endif
                        end else if (snooze_cnt_reg == 4'd1) begin
                            state_reg      <= RINGING;
                            snooze_cnt_reg <= '0;
                            ring_reg       <= 1'b1;
`ifdef RING_TIMEOUT_EN
                            ring_cnt_reg   <= '0;
`endif
                        end else begin
                            snooze_cnt_reg <= snooze_cnt_reg - 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    ring_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign alarm_time_ms_hr  = rd_time[15:12];
    assign alarm_time_ls_hr  = rd_time[11:8];
    assign alarm_time_ms_min = rd_time[7:4];
    assign alarm_time_ls_min = rd_time[3:0];
    assign rd_slot_en        = rd_en;
    assign alarm_ring        = ring_reg;
    assign alarm_hit_slot    = hit_slot_reg;
    assign load_err          = load_err_reg;

endmodule

// File: tb/tb_alarm_bank.sv
// -----------------------------------------------------------------------------
// tb_alarm_bank
//
// Directed bench for alarm_bank built with five slots (3-bit slot index), so
// that slot index 5 exercises the out-of-range load path.
// Times are written as packed BCD words, e.g. 16'h0730 = 07:30.
// -----------------------------------------------------------------------------
module tb_alarm_bank;

    localparam int NA = 5;
    localparam int SW = 3;

    logic          clock;
    logic          reset;
    logic          load_new_alarm;
    logic [SW-1:0] load_slot;
    logic [15:0]   new_time;
    logic          clear_slot_en;
    logic          time_tick;
    logic [15:0]   cur_time;
    logic          stop_alarm;
    logic          snooze;
    logic [SW-1:0] rd_slot;
    logic [3:0]    alarm_time_ms_hr;
    logic [3:0]    alarm_time_ls_hr;
    logic [3:0]    alarm_time_ms_min;
    logic [3:0]    alarm_time_ls_min;
    logic          rd_slot_en;
    logic          alarm_ring;
    logic [SW-1:0] alarm_hit_slot;
    logic          load_err;

    int checks = 0;
    int errors = 0;

    alarm_bank #(
        .NUM_ALARMS(NA),
        .SNOOZE_MIN(5),
        .RING_TICKS(10)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .load_new_alarm   (load_new_alarm),
        .load_slot        (load_slot),
        .new_alarm_ms_hr  (new_time[15:12]),
        .new_alarm_ls_hr  (new_time[11:8]),
        .new_alarm_ms_min (new_time[7:4]),
        .new_alarm_ls_min (new_time[3:0]),
        .clear_slot_en    (clear_slot_en),
        .time_tick        (time_tick),
        .cur_ms_hr        (cur_time[15:12]),
        .cur_ls_hr        (cur_time[11:8]),
        .cur_ms_min       (cur_time[7:4]),
        .cur_ls_min       (cur_time[3:0]),
        .stop_alarm       (stop_alarm),
        .snooze           (snooze),
        .rd_slot          (rd_slot),
        .alarm_time_ms_hr (alarm_time_ms_hr),
        .alarm_time_ls_hr (alarm_time_ls_hr),
        .alarm_time_ms_min(alarm_time_ms_min),
        .alarm_time_ls_min(alarm_time_ls_min),
        .rd_slot_en       (rd_slot_en),
        .alarm_ring       (alarm_ring),
        .alarm_hit_slot   (alarm_hit_slot),
        .load_err         (load_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are stable 1 ns later.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_load(input logic [SW-1:0] slot, input logic [15:0] t);
        load_new_alarm = 1'b1;
        load_slot      = slot;
        new_time       = t;
        cyc();
        load_new_alarm = 1'b0;
        $display("load slot=%0d time=%04h load_err=%0b", slot, t, load_err);
    endtask

    task automatic do_tick(input logic [15:0] t);
        time_tick = 1'b1;
        cur_time  = t;
        cyc();
        time_tick = 1'b0;
        $display("tick time=%04h ring=%0b hit=%0d", t, alarm_ring, alarm_hit_slot);
    endtask

    task automatic chk_slot(input string tag, input logic [SW-1:0] slot,
                            input logic [15:0] t, input logic en);
        rd_slot = slot;
        #1;
        chk({tag, "_time"}, {16'h0, alarm_time_ms_hr, alarm_time_ls_hr,
                             alarm_time_ms_min, alarm_time_ls_min}, {16'h0, t});
        chk({tag, "_en"}, {31'h0, rd_slot_en}, {31'h0, en});
    endtask

    initial begin
        reset          = 1'b1;
        load_new_alarm = 1'b0;
        load_slot      = '0;
        new_time       = '0;
        clear_slot_en  = 1'b0;
        time_tick      = 1'b0;
        cur_time       = '0;
        stop_alarm     = 1'b0;
        snooze         = 1'b0;
        rd_slot        = '0;
        cyc();
        cyc();

        // Reset state
        chk("rst_ring", {31'h0, alarm_ring}, 32'h0);
        chk("rst_hit", {29'h0, alarm_hit_slot}, 32'h0);
        chk("rst_err", {31'h0, load_err}, 32'h0);
        chk_slot("rst_s0", 3'd0, 16'h0000, 1'b0);
        reset = 1'b0;
        cyc();

        // Valid load into slot 2
        do_load(3'd2, 16'h0730);
        chk("ld_ok_err", {31'h0, load_err}, 32'h0);
        chk_slot("ld_s2", 3'd2, 16'h0730, 1'b1);
        chk_slot("ld_s1", 3'd1, 16'h0000, 1'b0);
        cyc();
        chk_slot("ld_s0", 3'd0, 16'h0000, 1'b0);
        chk_slot("ld_s3", 3'd3, 16'h0000, 1'b0);

        // Rejected loads: hour 24, minute 60, slot out of range
        do_load(3'd1, 16'h2400);
        chk("bad_hr_err", {31'h0, load_err}, 32'h1);
        chk_slot("bad_hr_s1", 3'd1, 16'h0000, 1'b0);
        cyc();
        chk("bad_hr_err_pulse", {31'h0, load_err}, 32'h0);
        do_load(3'd1, 16'h1260);
        chk("bad_min_err", {31'h0, load_err}, 32'h1);
        chk_slot("bad_min_s1", 3'd1, 16'h0000, 1'b0);
        cyc();
        chk("bad_min_err_pulse", {31'h0, load_err}, 32'h0);
        do_load(3'd5, 16'h0600);
        chk("bad_slot_err", {31'h0, load_err}, 32'h1);
        chk_slot("bad_slot_s2", 3'd2, 16'h0730, 1'b1);
        cyc();
        chk("bad_slot_err_pulse", {31'h0, load_err}, 32'h0);

        // Upper boundary of a valid time is accepted
        do_load(3'd4, 16'h2359);
        chk("edge_err", {31'h0, load_err}, 32'h0);
        chk_slot("edge_s4", 3'd4, 16'h2359, 1'b1);

        // Two slots with same time: lowest index wins
        do_load(3'd3, 16'h0615);
        do_load(3'd0, 16'h0615);
        do_tick(16'h0615);
        chk("prio_ring", {31'h0, alarm_ring}, 32'h1);
        chk("prio_hit", {29'h0, alarm_hit_slot}, 32'h0);
        do_tick(16'h0616);
        chk("ring_hold", {31'h0, alarm_ring}, 32'h1);
        do_tick(16'h0730);
        chk("ring_ignore_match_hit", {29'h0, alarm_hit_slot}, 32'h0);

        // Snooze, then re-ring on the 5th non-matching tick
        snooze = 1'b1;
        cyc();
        snooze = 1'b0;
        chk("snz_ring", {31'h0, alarm_ring}, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            do_tick(16'h0800 + 16'(i));
            chk("snz_wait", {31'h0, alarm_ring}, 32'h0);
        end
        do_tick(16'h0805);
        chk("snz_rering", {31'h0, alarm_ring}, 32'h1);
        chk("snz_rering_hit", {29'h0, alarm_hit_slot}, 32'h0);

        // Stop together with snooze: stop wins
        stop_alarm = 1'b1;
        snooze     = 1'b1;
        cyc();
        stop_alarm = 1'b0;
        snooze     = 1'b0;
        chk("stop_win_ring", {31'h0, alarm_ring}, 32'h0);
        do_tick(16'h0806);
        chk("stop_win_idle", {31'h0, alarm_ring}, 32'h0);

        // A match while snoozed re-rings with the new hit slot
        do_tick(16'h0615);
        snooze = 1'b1;
        cyc();
        snooze = 1'b0;
        do_tick(16'h0730);
        chk("snz_match_ring", {31'h0, alarm_ring}, 32'h1);
        chk("snz_match_hit", {29'h0, alarm_hit_slot}, 32'h2);
        stop_alarm = 1'b1;
        cyc();
        stop_alarm = 1'b0;

        // Cleared slot does not ring
        clear_slot_en = 1'b1;
        load_slot     = 3'd2;
        cyc();
        clear_slot_en = 1'b0;
        chk_slot("clr_s2", 3'd2, 16'h0730, 1'b0);
        do_tick(16'h0730);
        chk("clr_no_ring", {31'h0, alarm_ring}, 32'h0);

        // Load in the same cycle as a matching tick: pre-load contents used
        load_new_alarm = 1'b1;
        load_slot      = 3'd2;
        new_time       = 16'h0730;
        time_tick      = 1'b1;
        cur_time       = 16'h0730;
        cyc();
        load_new_alarm = 1'b0;
        time_tick      = 1'b0;
        chk("same_cyc_no_ring", {31'h0, alarm_ring}, 32'h0);
        chk_slot("same_cyc_s2", 3'd2, 16'h0730, 1'b1);
        do_tick(16'h0730);
        chk("reload_ring", {31'h0, alarm_ring}, 32'h1);
        chk("reload_hit", {29'h0, alarm_hit_slot}, 32'h2);

        // Clearing the hit slot does not stop the ring
        clear_slot_en = 1'b1;
        load_slot     = 3'd2;
        cyc();
        clear_slot_en = 1'b0;
        chk("clr_keep_ring", {31'h0, alarm_ring}, 32'h1);
        stop_alarm = 1'b1;
        cyc();
        stop_alarm = 1'b0;
        chk("stop_ring", {31'h0, alarm_ring}, 32'h0);

        // Clear together with load: load wins
        clear_slot_en  = 1'b1;
        load_new_alarm = 1'b1;
        load_slot      = 3'd2;
        new_time       = 16'h0730;
        cyc();
        clear_slot_en  = 1'b0;
        load_new_alarm = 1'b0;
        chk_slot("clr_ld_s2", 3'd2, 16'h0730, 1'b1);

        // Unattended ring
        do_tick(16'h0615);
        chk("long_start", {31'h0, alarm_ring}, 32'h1);
`ifdef RING_TIMEOUT_EN
        for (int i = 1; i <= 9; i++) begin
            do_tick(16'h0900 + 16'(i));
            chk("timeout_wait", {31'h0, alarm_ring}, 32'h1);
        end
        do_tick(16'h0910);
        chk("timeout_stop", {31'h0, alarm_ring}, 32'h0);
        do_tick(16'h0615);
        chk("timeout_rering", {31'h0, alarm_ring}, 32'h1);
`else
        for (int i = 1; i <= 20; i++) begin
            do_tick(16'h0900 + 16'(i));
        end
        chk("no_timeout", {31'h0, alarm_ring}, 32'h1);
`endif

        // Asynchronous reset during a ring
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_ring", {31'h0, alarm_ring}, 32'h0);
        chk_slot("async_rst_s2", 3'd2, 16'h0000, 1'b0);
        cyc();
        reset = 1'b0;
        cyc();
        chk("post_rst_ring", {31'h0, alarm_ring}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alarm_bank.md
Name: alarm_bank

Overview:
- Parametrised successor to the single-alarm register: holds NUM_ALARMS independent HH:MM alarm slots in BCD.
- Load-time BCD/range validation; per-slot enable.
- Compares enabled slots against the running clock time on each time tick.
- Ring/snooze state machine drives the alarm output. Sits between the time counter (current time, minute tick) and the display/sounder logic.

Parameters:
- NUM_ALARMS, 4, number of alarm slots (1..16).
- SNOOZE_MIN, 5, time ticks spent in SNOOZED before re-ringing (1..15).
- RING_TICKS, 10, time ticks before auto-stop; used only with RING_TIMEOUT_EN.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- load_new_alarm  in  1  write request for slot load_slot.
- load_slot  in  SW  target slot; SW = max(1, clog2(NUM_ALARMS)).
- new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min  in  4 each  BCD alarm time to load.
- clear_slot_en  in  1  pulse: disable slot load_slot.
- time_tick  in  1  one-cycle pulse when current time changes (once per minute).
- cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min  in  4 each  current BCD time, valid when time_tick=1.
- stop_alarm  in  1  pulse: silence alarm.
- snooze  in  1  pulse: snooze the ringing alarm.
- rd_slot  in  SW  read-back slot select.
- alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min  out  4 each  stored time of rd_slot (combinational mux of registers).
- rd_slot_en  out  1  enable flag of rd_slot.
- alarm_ring  out  1  high in RINGING.
- alarm_hit_slot  out  SW  slot that caused the current ring.
- load_err  out  1  one-cycle pulse, registered: rejected load.

Behaviour:
- Reset, asynchronous, active-high:
  - All slot digits 0 and all enables 0, so read-back outputs are 0.
  - State IDLE; alarm_ring=0, alarm_hit_slot=0, load_err=0; snooze and ring counters 0.
  - Reset mid-ring or mid-snooze returns to IDLE immediately.
- Load:
  - If load_new_alarm=1, load_slot<NUM_ALARMS and the time is valid, all four digits of that slot and en=1 are written at the next edge.
  - Valid time: ms_hr<=2; ls_hr<=9, or <=3 when ms_hr=2; ms_min<=5; ls_min<=9.
  - Invalid digits or slot index >= NUM_ALARMS: no write, and load_err=1 on the next cycle.
- clear_slot_en clears en of load_slot. If asserted together with load_new_alarm, load wins (en=1).
- Compare, on time_tick=1 only:
  - Slot i matches when en[i]=1 and all four digits equal the cur_* digits.
  - Registered contents before any same-cycle load are used.
  - With multiple matches, the lowest index wins.
- FSM states: IDLE, RINGING, SNOOZED. Transitions on clock edge:
  - IDLE: tick with a match -> RINGING; alarm_hit_slot is set to the winning index.
  - RINGING: stop_alarm -> IDLE. Otherwise snooze -> SNOOZED with snooze_cnt=SNOOZE_MIN. Matches are ignored and alarm_hit_slot is held. stop_alarm together with snooze: stop wins.
  - SNOOZED: stop_alarm -> IDLE.
    - Tick with a match -> RINGING; alarm_hit_slot updated, snooze_cnt cleared.
    - Other ticks decrement snooze_cnt; a tick when snooze_cnt=1 -> RINGING with alarm_hit_slot unchanged.
    - snooze while SNOOZED is ignored.
- alarm_ring is registered: high starting the cycle after entry to RINGING, low the cycle after leaving it.
- Clearing or reloading the hit slot does not stop a ring in progress.
- Each time_tick pulse is consumed once; ticks are never queued.

Optional Feature:
- Macro RING_TIMEOUT_EN.
- Defined:
  - A ring counter loads 0 on entry to RINGING and increments per tick while RINGING.
  - When it reaches RING_TICKS the FSM goes to IDLE as if stop_alarm had been asserted.
  - The counter is not advanced while SNOOZED and is reloaded on re-entry to RINGING.
- Not defined: RINGING persists until stop_alarm, snooze or reset; RING_TICKS is unused and no counter is built.

Test Plan:
- Reset, then load slot 2 = 07:30 -> rd_slot=2 reads 0,7,3,0 with rd_slot_en=1; other slots read 0, en=0.
- Load slot 1 = 24:00, then 12:60, then load_slot=5 -> each rejected; load_err pulses one cycle; contents unchanged.
- Slots 0 and 3 both 06:15; tick with cur=06:15 -> RINGING, alarm_hit_slot=0; a tick at 06:16 changes nothing.
- Ringing, snooze pulse -> SNOOZED. 5 ticks with no match -> RINGING on the 5th, alarm_ring=1; stop_alarm together with snooze -> IDLE.
- clear_slot_en on slot 2 (07:30) then tick at 07:30 -> no ring. Load slot 2 with 07:30 in the same cycle as a tick at 07:30 -> no ring (pre-load contents used).
- With RING_TIMEOUT_EN: ring with no user input -> IDLE after the 10th tick. Without the macro -> still RINGING after 20 ticks. Reset during RINGING -> alarm_ring=0 immediately.
